// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding,
// datapath widths and IF/ID bus field offsets.
package pipe_pkg;

  localparam int INST_W = 32;
  localparam int IFID_W = 64;

  localparam int IF_PC4_LSB   = 0;
  localparam int IF_INSTR_LSB = 32;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  function automatic logic [31:0] pc_inc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, talks to imem,
// buffers across holds and drops stale responses.
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [IFID_W-1:0] if_out,
  output logic              if_bubble
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [31:0]       pc;
  logic [31:0]       pc_nxt;
  logic [INST_W-1:0] ibuf;
  logic [INST_W-1:0] ibuf_nxt;
  logic              buf_valid;
  logic              bv_nxt;
  logic [31:0]       pend_pc;
  logic [31:0]       pend_nxt;

  logic              st_fetch;
  logic              st_stall;
  logic              st_drop;
  logic              redirect;
  logic [31:0]       target;
  logic              valid_now;
  logic              consume;
  logic [INST_W-1:0] instr;
  logic [31:0]       pc_plus4;

  assign st_fetch = (state == FETCH);
  assign st_stall = (state == STALL);
  assign st_drop  = (state == DROP);

  // Branch is older than the jump, so it wins.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target
                                 : jump_target;

  assign valid_now = buf_valid
                   | (st_fetch & imem_ready);
  assign instr     = buf_valid ? ibuf : imem_rdata;
  assign pc_plus4  = pc_inc(pc);
  assign consume   = valid_now & ~hold & ~redirect;

  assign imem_req  = rst_n & (st_fetch | st_drop);
  assign imem_addr = pc;
  assign if_bubble = ~rst_n | ~valid_now | redirect;

  assign if_out[IF_INSTR_LSB +: INST_W] = instr;
  assign if_out[IF_PC4_LSB +: 32]       = pc_plus4;

  // Next-state and next-PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ibuf_nxt  = ibuf;
    bv_nxt    = buf_valid;
    pend_nxt  = pend_pc;
    unique case (1'b1)
      st_fetch: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_nxt = target;
          end else begin
            pend_nxt  = target;
            state_nxt = DROP;
          end
        end else if (consume) begin
          pc_nxt = pc_plus4;
        end else if (imem_ready & hold) begin
          ibuf_nxt  = imem_rdata;
          bv_nxt    = 1'b1;
          state_nxt = STALL;
        end
      end
      st_stall: begin
        if (redirect) begin
          bv_nxt    = 1'b0;
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (consume) begin
          bv_nxt    = 1'b0;
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      st_drop: begin
        if (imem_ready) begin
          pc_nxt    = redirect ? target : pend_pc;
          state_nxt = FETCH;
        end else if (redirect) begin
          pend_nxt = target;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ibuf      <= '0;
      buf_valid <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ibuf      <= ibuf_nxt;
      buf_valid <= bv_nxt;
      pend_pc   <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero/multi-wait
// fetch, hold, redirects, drop, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [63:0] if_out;
  logic        if_bubble;

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_out       (if_out),
    .if_bubble    (if_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // One cycle: drive after posedge, settle to negedge.
  task automatic cyc(
    input logic        rdy,
    input logic [31:0] rd,
    input logic        hld,
    input logic        br,
    input logic [31:0] bt,
    input logic        jp,
    input logic [31:0] jt
  );
    @(posedge clk);
    #1;
    imem_ready    = rdy;
    imem_rdata    = rd;
    hold          = hld;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    @(negedge clk);
  endtask

  logic [31:0] prog [3];
  logic [31:0] base;

  initial begin
    checks        = 0;
    failures      = 0;
    prog[0]       = 32'h0000_0013;
    prog[1]       = 32'h0010_0093;
    prog[2]       = 32'h0020_0113;
    hold          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    imem_ready    = 1'b1;
    imem_rdata    = 32'h1111_1111;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;

    @(negedge clk);
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_bub", {63'd0, if_bubble}, 64'd1);
    check("rst_addr", {32'd0, imem_addr},
          {32'd0, RPC});
    #2;
    imem_ready = 1'b0;
    rst_n      = 1'b1;

    // zero-wait streaming
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, prog[i], 1'b0, 1'b0, 0, 1'b0, 0);
      check("zw_req", {63'd0, imem_req}, 64'd1);
      check("zw_addr", {32'd0, imem_addr},
            {32'd0, RPC + 32'(4 * i)});
      check("zw_bub", {63'd0, if_bubble}, 64'd0);
      check("zw_out", if_out,
            {prog[i], RPC + 32'(4 * i + 4)});
    end

    // two wait states per instruction
    for (int r = 0; r < 2; r++) begin
      base = 32'h0040_000C + 32'(4 * r);
      for (int w = 0; w < 2; w++) begin
        cyc(1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 0,
            1'b0, 0);
        check("ws_bub", {63'd0, if_bubble}, 64'd1);
        check("ws_addr", {32'd0, imem_addr},
              {32'd0, base});
      end
      cyc(1'b1, 32'h00A0_0513 + 32'(r), 1'b0,
          1'b0, 0, 1'b0, 0);
      check("ws_rdy_bub", {63'd0, if_bubble},
            64'd0);
      check("ws_out", if_out,
            {32'h00A0_0513 + 32'(r), base + 32'd4});
    end

    // jump to 0x100 then hold for 3 cycles
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b1,
        32'h0000_0100);
    check("jmp_bub", {63'd0, if_bubble}, 64'd1);
    cyc(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 0, 1'b0, 0);
    check("hd_addr", {32'd0, imem_addr}, 64'h100);
    check("hd_bub", {63'd0, if_bubble}, 64'd0);
    check("hd_out", if_out,
          64'h8C01_0004_0000_0104);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 0);
      check("st_req", {63'd0, imem_req}, 64'd0);
      check("st_bub", {63'd0, if_bubble}, 64'd0);
      check("st_out", if_out,
            64'h8C01_0004_0000_0104);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("rel_out", if_out,
          64'h8C01_0004_0000_0104);
    check("rel_bub", {63'd0, if_bubble}, 64'd0);

    // branch while 0x104 is outstanding
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("nx_req", {63'd0, imem_req}, 64'd1);
    check("nx_addr", {32'd0, imem_addr}, 64'h104);
    check("nx_bub", {63'd0, if_bubble}, 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200,
        1'b0, 0);
    check("br_bub", {63'd0, if_bubble}, 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("dr_bub", {63'd0, if_bubble}, 64'd1);
    check("dr_addr", {32'd0, imem_addr}, 64'h104);
    check("dr_req", {63'd0, imem_req}, 64'd1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0,
        1'b0, 0);
    check("dr_rdy_bub", {63'd0, if_bubble}, 64'd1);
    check("dr_rdy_adr", {32'd0, imem_addr},
          64'h104);
    cyc(1'b1, 32'h0000_0033, 1'b0, 1'b0, 0,
        1'b0, 0);
    check("tg_addr", {32'd0, imem_addr}, 64'h200);
    check("tg_out", if_out,
          64'h0000_0033_0000_0204);

    // branch beats jump
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0300,
        1'b1, 32'h0000_0500);
    check("bj_bub", {63'd0, if_bubble}, 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("bj_addr", {32'd0, imem_addr}, 64'h300);

    // latest redirect in DROP wins
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1,
        32'h0000_0600);
    check("ov_bub0", {63'd0, if_bubble}, 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0700,
        1'b0, 0);
    check("ov_addr", {32'd0, imem_addr}, 64'h300);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("ov_bub1", {63'd0, if_bubble}, 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("ov_tgt", {32'd0, imem_addr}, 64'h700);

    // pc+4 wraps at the top of memory
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b1,
        32'hFFFF_FFFC);
    cyc(1'b1, 32'h0000_006F, 1'b0, 1'b0, 0,
        1'b0, 0);
    check("wr_addr", {32'd0, imem_addr},
          64'hFFFF_FFFC);
    check("wr_out", if_out,
          64'h0000_006F_0000_0000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("wr_next", {32'd0, imem_addr}, 64'h0);

    // reset while stalled
    cyc(1'b1, 32'h1234_5013, 1'b1, 1'b0, 0,
        1'b0, 0);
    check("rs_bub", {63'd0, if_bubble}, 64'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 0);
    check("rs_st_req", {63'd0, imem_req}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rs_req", {63'd0, imem_req}, 64'd0);
    check("rs_bubr", {63'd0, if_bubble}, 64'd1);
    check("rs_pc", {32'd0, imem_addr},
          {32'd0, RPC});
    hold = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 32'h0000_0073, 1'b0, 1'b0, 0,
        1'b0, 0);
    check("rs2_req", {63'd0, imem_req}, 64'd1);
    check("rs2_addr", {32'd0, imem_addr},
          {32'd0, RPC});
    check("rs2_bub", {63'd0, if_bubble}, 64'd0);
    check("rs2_out", if_out,
          {32'h0000_0073, RPC + 32'd4});

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
